// File: rtl/alu_arb_if.sv
// Shared ALU bus between the arbiter and the external ALU.
// The arbiter drives select and operands; the ALU returns the result and MSB.
interface alu_arb_if;
   logic [2:0]  alu_sel;
   logic [31:0] alu_rs1;
   logic [31:0] alu_rs2;
   logic [31:0] alu_sal;
   logic        alu_msb;

   modport master (
      output alu_sel,
      output alu_rs1,
      output alu_rs2,
      input  alu_sal,
      input  alu_msb
   );

   modport slave (
      input  alu_sel,
      input  alu_rs1,
      input  alu_rs2,
      output alu_sal,
      output alu_msb
   );
endinterface

// File: rtl/alu_arb.sv
// Two-requester round-robin arbiter in front of a shared external ALU.
// Fixed three-cycle turnaround: grant, execute, respond.
module alu_arb #(
   parameter bit RR_INIT = 1'b0,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [2:0]       op_a,
   input  logic [2:0]       op_b,
   input  logic [31:0]      a_a,
   input  logic [31:0]      b_a,
   input  logic [31:0]      a_b,
   input  logic [31:0]      b_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             done_a,
   output logic             done_b,
   output logic [31:0]      res,
   output logic             msb,
   output logic             busy,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b,
   alu_arb_if.master        alu
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t      state;
   state_t      state_nx;
   logic        last_b;
   logic        own_b;
   logic [2:0]  sel_q;
   logic [31:0] rs1_q;
   logic [31:0] rs2_q;
   logic        pick_a;
   logic        pick_b;

   // last_b set means B won most recently, so A takes the next tie
   assign pick_a = req_a & (~req_b | last_b);
   assign pick_b = req_b & (~req_a | ~last_b);

   always_comb begin
      state_nx = state;
      gnt_a    = 1'b0;
      gnt_b    = 1'b0;
      done_a   = 1'b0;
      done_b   = 1'b0;
      unique case (state)
         IDLE: begin
            if (rst_n && (req_a || req_b)) begin
               gnt_a    = pick_a;
               gnt_b    = pick_b;
               state_nx = EXEC;
            end
         end
         EXEC: state_nx = RESP;
         RESP: begin
            state_nx = IDLE;
            done_a   = rst_n & ~own_b;
            done_b   = rst_n & own_b;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = rst_n && (state != IDLE);

   assign alu.alu_sel = sel_q;
   assign alu.alu_rs1 = rs1_q;
   assign alu.alu_rs2 = rs2_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         last_b <= ~RR_INIT;
         own_b  <= 1'b0;
         sel_q  <= 3'd0;
         rs1_q  <= 32'd0;
         rs2_q  <= 32'd0;
         res    <= 32'd0;
         msb    <= 1'b0;
         cnt_a  <= '0;
         cnt_b  <= '0;
      end else begin
         state <= state_nx;
         if (gnt_a || gnt_b) begin
            last_b <= gnt_b;
            own_b  <= gnt_b;
            sel_q  <= gnt_b ? op_b : op_a;
            rs1_q  <= gnt_b ? a_b : a_a;
            rs2_q  <= gnt_b ? b_b : b_a;
         end
         if (state == EXEC) begin
            res <= alu.alu_sal;
            msb <= alu.alu_msb;
         end
         if (gnt_a && (cnt_a != '1)) cnt_a <= cnt_a + ONE;
         if (gnt_b && (cnt_b != '1)) cnt_b <= cnt_b + ONE;
      end
   end

endmodule

// File: tb/tb_alu_arb.sv
// Scoreboard bench for alu_arb with a behavioural ALU on the shared bus.
// A second instance with narrow counters exercises saturation.
module tb_alu_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_a = 1'b0, req_b = 1'b0;
   logic [2:0]  op_a = 3'd0, op_b = 3'd0;
   logic [31:0] a_a = 32'd0, b_a = 32'd0;
   logic [31:0] a_b = 32'd0, b_b = 32'd0;
   logic        gnt_a, gnt_b, done_a, done_b;
   logic [31:0] res;
   logic        msb, busy;
   logic [15:0] cnt_a, cnt_b;

   logic        r1a = 1'b0;
   logic        g1a, g1b, d1a, d1b, m1, busy1;
   logic [31:0] res1;
   logic [1:0]  c1a, c1b;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   typedef struct {
      logic        who;
      logic [31:0] res;
      logic        msb;
   } exp_t;

   exp_t sbq[$];
   exp_t e;

   alu_arb_if bus0 ();
   alu_arb_if bus1 ();

   function automatic logic [31:0] alu_ref(
      input logic [2:0] s, input logic [31:0] x, input logic [31:0] y);
      case (s)
         3'd0: return x + y;
         3'd1: return x & y;
         3'd2: return x ^ y;
         3'd3: return x << y[4:0];
         3'd4: return 32'($signed(x) >>> y[4:0]);
         3'd5: return x - y;
         3'd6: return (x + y) & 32'h0000_ffff;
         default: return 32'd0;
      endcase
   endfunction

   assign bus0.alu_sal = alu_ref(bus0.alu_sel, bus0.alu_rs1, bus0.alu_rs2);
   assign bus0.alu_msb = bus0.alu_sal[31];
   assign bus1.alu_sal = alu_ref(bus1.alu_sel, bus1.alu_rs1, bus1.alu_rs2);
   assign bus1.alu_msb = bus1.alu_sal[31];

   alu_arb #(.RR_INIT(1'b0), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .req_b(req_b),
      .op_a(op_a), .op_b(op_b),
      .a_a(a_a), .b_a(b_a), .a_b(a_b), .b_b(b_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b),
      .done_a(done_a), .done_b(done_b),
      .res(res), .msb(msb), .busy(busy),
      .cnt_a(cnt_a), .cnt_b(cnt_b),
      .alu(bus0)
   );

   alu_arb #(.RR_INIT(1'b1), .CNT_W(2)) u1 (
      .clk(clk), .rst_n(rst_n),
      .req_a(r1a), .req_b(1'b0),
      .op_a(3'd0), .op_b(3'd0),
      .a_a(32'd0), .b_a(32'd0), .a_b(32'd0), .b_b(32'd0),
      .gnt_a(g1a), .gnt_b(g1b),
      .done_a(d1a), .done_b(d1b),
      .res(res1), .msb(m1), .busy(busy1),
      .cnt_a(c1a), .cnt_b(c1b),
      .alu(bus1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag,
                      input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input logic who, input logic [31:0] r, input logic m);
      exp_t x;
      x.who = who;
      x.res = r;
      x.msb = m;
      sbq.push_back(x);
   endtask

   function automatic logic sig(input int which);
      case (which)
         0: return gnt_a;
         1: return gnt_b;
         2: return done_a;
         3: return done_b;
         4: return g1a;
         default: return gnt_a | gnt_b;
      endcase
   endfunction

   task automatic wait_ev(input int which, output int at);
      at = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sig(which)) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         checks++;
         errors++;
         $display("FAIL timeout event %0d t=%0t", which, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      sbq.delete();
   endtask

   always @(negedge clk) begin
      if (gnt_a || gnt_b || done_a || done_b)
         chk("onehot", $countones({gnt_a, gnt_b, done_a, done_b}), 1);
      if (done_a || done_b) begin
         done_seen++;
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty done with nothing expected t=%0t", $time);
         end else begin
            e = sbq.pop_front();
            chk("sb_who", done_b, e.who);
            chk("sb_res", res, e.res);
            chk("sb_msb", msb, e.msb);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, d, t, prev, dn0;

      // reset state
      do_reset();
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", {gnt_a, gnt_b, done_a, done_b}, 0);
      chk("rst_res", res, 0);
      chk("rst_msb", msb, 0);
      chk("rst_cnt", {cnt_a, cnt_b}, 0);
      chk("rst_sel", bus0.alu_sel, 0);
      chk("rst_rs", bus0.alu_rs1 | bus0.alu_rs2, 0);

      // single op, operands change after grant
      tick();
      req_a = 1'b1; op_a = 3'd0; a_a = 32'd5; b_a = 32'd7;
      push(1'b0, 32'd12, 1'b0);
      wait_ev(0, n);
      tick();
      req_a = 1'b0; op_a = 3'd3; a_a = 32'hdead_beef; b_a = 32'h1234_5678;
      @(negedge clk);
      chk("t1_rs1", bus0.alu_rs1, 32'd5);
      chk("t1_rs2", bus0.alu_rs2, 32'd7);
      chk("t1_sel", bus0.alu_sel, 3'd0);
      chk("t1_busy", busy, 1);
      wait_ev(2, d);
      chk("t1_lat", d - n, 2);
      chk("t1_res", res, 32'd12);
      @(negedge clk);
      chk("t1_cnt_a", cnt_a, 1);
      chk("t1_idle", busy, 0);
      chk("t1_hold", res, 32'd12);

      // held tie after reset alternates A, B, A, B
      do_reset();
      req_a = 1'b1; op_a = 3'd1; a_a = 32'h0000_f0f0; b_a = 32'h0000_ff00;
      req_b = 1'b1; op_b = 3'd2; a_b = 32'hffff_0000; b_b = 32'h0f0f_0f0f;
      push(1'b0, 32'h0000_f000, 1'b0);
      push(1'b1, 32'hf0f0_0f0f, 1'b1);
      push(1'b0, 32'h0000_f000, 1'b0);
      push(1'b1, 32'hf0f0_0f0f, 1'b1);
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         wait_ev(5, t);
         chk("t2_who", gnt_b, k % 2);
         if (k > 0) chk("t2_gap", t - prev, 3);
         prev = t;
      end
      tick();
      req_a = 1'b0; req_b = 1'b0;
      wait_ev(3, d);
      chk("t2_cnt_a", cnt_a, 2);
      chk("t2_cnt_b", cnt_b, 2);

      // subtract with negative result
      tick();
      req_b = 1'b1; op_b = 3'd5; a_b = 32'd3; b_b = 32'd4;
      push(1'b1, 32'hffff_ffff, 1'b1);
      wait_ev(1, n);
      tick();
      req_b = 1'b0;
      wait_ev(3, d);
      chk("t3_lat", d - n, 2);
      chk("t3_res", res, 32'hffff_ffff);
      chk("t3_msb", msb, 1);

      // reset during EXEC aborts
      tick();
      req_a = 1'b1; op_a = 3'd0; a_a = 32'd1; b_a = 32'd1;
      wait_ev(0, n);
      tick();
      req_a = 1'b0;
      rst_n = 1'b0;
      dn0 = done_seen;
      tick();
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t5_nodone", done_seen, dn0);
      chk("t5_res", res, 0);
      chk("t5_msb", msb, 0);
      chk("t5_cnt", {cnt_a, cnt_b}, 0);
      chk("t5_busy", busy, 0);
      chk("t5_rs1", bus0.alu_rs1, 0);

      // busy lockout after reset
      tick();
      req_a = 1'b1; op_a = 3'd6; a_a = 32'h1234_5678; b_a = 32'h1111_1111;
      push(1'b0, 32'h0000_6789, 1'b0);
      wait_ev(0, n);
      tick();
      req_a = 1'b0;
      req_b = 1'b1; op_b = 3'd7; a_b = 32'hffff_ffff; b_b = 32'd1;
      push(1'b1, 32'd0, 1'b0);
      @(negedge clk);
      chk("t4_busy1", busy, 1);
      chk("t4_lock1", gnt_b, 0);
      @(negedge clk);
      chk("t4_busy2", busy, 1);
      chk("t4_lock2", gnt_b, 0);
      chk("t4_done_a", done_a, 1);
      wait_ev(1, t);
      chk("t4_gap", t - n, 3);
      chk("t4_idle", busy, 0);
      tick();
      req_b = 1'b0;
      @(negedge clk);
      chk("t4_busy3", busy, 1);
      @(negedge clk);
      chk("t4_busy4", busy, 1);
      @(negedge clk);
      chk("t4_busy5", busy, 0);
      chk("t4_cnt_b", cnt_b, 1);
      chk("t4_sb", sbq.size(), 0);

      // counter saturation on the narrow instance
      tick();
      r1a = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_ev(4, t);
         @(negedge clk);
         chk("t6_cnt", c1a, (k < 3) ? k + 1 : 3);
      end
      r1a = 1'b0;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter RR_INIT, default 0, meaning the requester favoured after reset (0 = A, 1 = B).
REQ-002 Parameter CNT_W, default 16, meaning the width of each per-requester grant counter.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst_n  input  1  synchronous active-low reset, sampled on clk.
REQ-006 Port req_a / req_b  input  1  operation request from requester A / B, level, held until granted.
REQ-007 Port op_a / op_b  input  3  ALU select code (0 add, 1 and, 2 xor, 3 sll, 4 sra, 5 sub, 6 add-and-mask, 7 zero).
REQ-008 Port a_a, b_a / a_b, b_b  input  32  operands rs1 and rs2 for requester A / B.
REQ-009 Port gnt_a / gnt_b  output  1  one-cycle pulse; the request and operands were accepted this cycle.
REQ-010 Port done_a / done_b  output  1  one-cycle pulse; res and msb are valid for that requester.
REQ-011 Port res  output  32  registered ALU result.
REQ-012 Port msb  output  1  registered ALU MSB flag.
REQ-013 Port busy  output  1  high whenever the FSM is not IDLE.
REQ-014 Port alu_sel  output  3  select code driven to the shared ALU.
REQ-015 Port alu_rs1, alu_rs2  output  32  operands driven to the shared ALU.
REQ-016 Port alu_sal  input  32  ALU result.
REQ-017 Port alu_msb  input  1  ALU MSB flag.
REQ-018 Port cnt_a / cnt_b  output  CNT_W  number of grants issued to A / B; saturates at all-ones.

Function
REQ-019 The FSM SHALL have three states:
- IDLE -> EXEC when any request is granted
- EXEC -> RESP unconditionally
- RESP -> IDLE unconditionally
REQ-020 In IDLE with exactly one req high, that requester SHALL be granted: its gnt pulses that cycle, and op and operands are latched into internal registers.
REQ-021 In IDLE with req_a and req_b both high, the requester not granted most recently SHALL win; the other requester's req remains pending.
REQ-022 A round-robin pointer SHALL record the last winner and update only on a grant.
REQ-023 alu_sel, alu_rs1 and alu_rs2 SHALL be driven from the latched registers in all states, so the ALU inputs are stable throughout EXEC.
REQ-024 At the end of EXEC, alu_sal and alu_msb SHALL be captured into res and msb.
REQ-025 In RESP, exactly one done pulse SHALL be asserted, for the granted requester.
REQ-026 Latency SHALL be fixed: a grant in cycle N gives done in cycle N+2, and the next grant occurs no earlier than cycle N+3.
REQ-027 Requests arriving while busy SHALL be ignored until IDLE; no request is queued beyond the level-held req.
REQ-028 Deassertion of req after gnt SHALL NOT affect the operation in flight.
REQ-029 res and msb SHALL hold their last values until the next capture.
REQ-030 gnt_a, gnt_b, done_a and done_b SHALL never be high in the same cycle as each other.
REQ-031 Each cnt SHALL increment by 1 on its gnt and saturate at 2^CNT_W-1 without wrapping.
REQ-032 The block SHALL contain no arithmetic on operands; all data computation is performed by the external ALU.

Reset
REQ-033 While rst_n=0 at a clk edge, the block SHALL reset to:
- FSM = IDLE
- gnt_*, done_*, busy = 0
- res = 0, msb = 0
- latched op/operands = 0, so alu_sel = 0 and alu_rs1 = alu_rs2 = 0
- cnt_* = 0
- round-robin pointer set so that the RR_INIT requester wins the first tie
REQ-034 A reset during EXEC or RESP SHALL abort the operation: no done pulse is issued, and after reset is released the FSM is in IDLE.

Verification
REQ-035 Single op: req_a=1, op_a=0, a_a=5, b_a=7 in IDLE -> gnt_a in cycle N, alu_rs1=5 and alu_rs2=7 in cycle N+1, done_a with res=12 and msb=0 in cycle N+2, cnt_a=1.
REQ-036 Tie after reset (RR_INIT=0): req_a and req_b high together and held -> A granted first, B granted 3 cycles later; on the next tie B loses only if it won the previous grant.
REQ-037 Sub sign: op_b=5, a_b=3, b_b=4 -> done_b with res=32'hFFFFFFFF and msb=1.
REQ-038 Busy lockout: req_b rises in the cycle after gnt_a -> no gnt_b until the cycle after done_a; busy=1 for exactly 2 cycles per operation.
REQ-039 Reset abort: rst_n=0 in EXEC -> no done pulse; res=0, cnt_*=0, busy=0; the first request after reset completes normally.
REQ-040 Saturation (CNT_W=2): 5 grants to A -> cnt_a sequence 1, 2, 3, 3, 3.
